// File: rtl/ccc_lock_rst_seq.sv
// Staged reset sequencer for fabric driven by the MSS CCC: qualifies PLL lock,
// releases three reset stages in order, provides a RUN-time tick and lock-loss counter.
module ccc_lock_rst_seq #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned STAGE_GAP     = 16,
   parameter int unsigned TICK_DIV      = 100
) (
   input  logic       FAB_CLK,
   input  logic       M2F_RESET_N,
   input  logic       FAB_LOCK,
   input  logic       CLR_LOSS,
   output logic       RST_N_STAGE0,
   output logic       RST_N_STAGE1,
   output logic       RST_N_STAGE2,
   output logic       LOCK_OK,
   output logic       TICK,
   output logic [7:0] LOSS_COUNT
);

   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] GAP_LAST    = 16'(STAGE_GAP - 1);
   localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK,
      STABILIZE,
      REL0,
      REL1,
      RUN
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] div_q, div_d;
   logic        lock_m_q, lock_s_q;
   logic        tick_q, tick_d;
   logic        rst0_q, rst0_d;
   logic        rst1_q, rst1_d;
   logic        rst2_q, rst2_d;
   logic        ok_q, ok_d;
   logic [7:0]  loss_q, loss_d;
   logic        loss_ev;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      loss_ev = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = STABILIZE;
               cnt_d   = '0;
            end
         end
         STABILIZE: begin
            if (cnt_q == STABLE_LAST) begin
               state_d = REL0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         REL0: begin
            if (cnt_q == GAP_LAST) begin
               state_d = REL1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         REL1: begin
            if (cnt_q == GAP_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RUN: begin
            cnt_d = '0;
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      // Lock loss overrides every transition above, including stage releases.
      if ((state_q != WAIT_LOCK) && !lock_s_q) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         loss_ev = 1'b1;
      end

      div_d  = '0;
      tick_d = 1'b0;
      if ((state_q == RUN) && (state_d == RUN)) begin
         if (div_q == TICK_LAST) begin
            tick_d = 1'b1;
         end else begin
            div_d = div_q + 16'd1;
         end
      end

      rst0_d = (state_d == REL0) || (state_d == REL1) || (state_d == RUN);
      rst1_d = (state_d == REL1) || (state_d == RUN);
      rst2_d = (state_d == RUN);
      ok_d   = (state_d == RUN);

      if (CLR_LOSS) begin
         loss_d = {7'd0, loss_ev};
      end else if (loss_ev && (loss_q != 8'hFF)) begin
         loss_d = loss_q + 8'd1;
      end else begin
         loss_d = loss_q;
      end
   end

   always_ff @(posedge FAB_CLK) begin
      if (!M2F_RESET_N) begin
         lock_m_q <= 1'b0;
         lock_s_q <= 1'b0;
         state_q  <= WAIT_LOCK;
         cnt_q    <= '0;
         div_q    <= '0;
         tick_q   <= 1'b0;
         rst0_q   <= 1'b0;
         rst1_q   <= 1'b0;
         rst2_q   <= 1'b0;
         ok_q     <= 1'b0;
         loss_q   <= '0;
      end else begin
         lock_m_q <= FAB_LOCK;
         lock_s_q <= lock_m_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         tick_q   <= tick_d;
         rst0_q   <= rst0_d;
         rst1_q   <= rst1_d;
         rst2_q   <= rst2_d;
         ok_q     <= ok_d;
         loss_q   <= loss_d;
      end
   end

   assign RST_N_STAGE0 = rst0_q;
   assign RST_N_STAGE1 = rst1_q;
   assign RST_N_STAGE2 = rst2_q;
   assign LOCK_OK      = ok_q;
   assign TICK         = tick_q;
   assign LOSS_COUNT   = loss_q;

endmodule

// File: doc/ccc_lock_rst_seq.md
CCC_LOCK_RST_SEQ -- requirements
Module: ccc_lock_rst_seq

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before the first reset release (legal 2..65535).
REQ-002 The block SHALL have parameter STAGE_GAP, default 16: cycles between successive stage releases (legal 1..255).
REQ-003 The block SHALL have parameter TICK_DIV, default 100: FAB_CLK cycles per TICK period (legal 2..65535).
REQ-004 Port FAB_CLK, input, 1 bit: the single clock, the fabric clock from the MSS CCC.
REQ-005 Port M2F_RESET_N, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port FAB_LOCK, input, 1 bit: CCC PLL lock, asynchronous to FAB_CLK.
REQ-007 Port CLR_LOSS, input, 1 bit: one-cycle request to clear LOSS_COUNT.
REQ-008 Port RST_N_STAGE0, output, 1 bit: active-low reset for stage 0, the bus/APB fabric.
REQ-009 Port RST_N_STAGE1, output, 1 bit: active-low reset for stage 1, the peripheral cores.
REQ-010 Port RST_N_STAGE2, output, 1 bit: active-low reset for stage 2, application logic.
REQ-011 Port LOCK_OK, output, 1 bit: high only while in RUN.
REQ-012 Port TICK, output, 1 bit: one-cycle strobe every TICK_DIV cycles while in RUN.
REQ-013 Port LOSS_COUNT, output, 8 bits: saturating count of lock-loss events.

Function
REQ-014 FAB_LOCK SHALL pass through a 2-flop synchronizer; lock_s is the second flop, and only lock_s SHALL be used internally.
REQ-015 The FSM SHALL have the states WAIT_LOCK, STABILIZE, REL0, REL1 and RUN, with a 16-bit cycle counter cnt.
REQ-016 WAIT_LOCK: if lock_s=1, the next state SHALL be STABILIZE with cnt=0; otherwise the FSM SHALL remain in WAIT_LOCK.
REQ-017 STABILIZE: if cnt==STABLE_CYCLES-1, the next state SHALL be REL0 with cnt=0; otherwise cnt SHALL increment.
REQ-018 REL0: if cnt==STAGE_GAP-1, the next state SHALL be REL1 with cnt=0; otherwise cnt SHALL increment.
REQ-019 REL1: if cnt==STAGE_GAP-1, the next state SHALL be RUN with cnt=0; otherwise cnt SHALL increment.
REQ-020 In STABILIZE, REL0, REL1 and RUN, lock_s=0 SHALL take priority over every other transition: next state WAIT_LOCK, cnt=0, LOSS_COUNT incremented.
REQ-021 All outputs SHALL be registered and SHALL update on the same edge as the state register.
REQ-022 RST_N_STAGE0 SHALL be 1 iff the state is REL0, REL1 or RUN; RST_N_STAGE1 SHALL be 1 iff the state is REL1 or RUN; RST_N_STAGE2 SHALL be 1 iff the state is RUN.
REQ-023 Reset assertion on lock loss SHALL take effect on all three stages on the same edge; only release SHALL be staggered.
REQ-024 Latency: with FAB_LOCK first high at sampling edge s, RST_N_STAGE0 SHALL rise after edge s+2+STABLE_CYCLES, RST_N_STAGE1 STAGE_GAP edges later, and RST_N_STAGE2 and LOCK_OK a further STAGE_GAP edges later.
REQ-025 The tick divider SHALL be held at 0 outside RUN; in RUN it SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-026 TICK SHALL be 1 for exactly the one cycle after the edge at which the divider wraps; the first TICK SHALL occur TICK_DIV cycles after entering RUN.
REQ-027 A lock loss SHALL clear the divider and force TICK to 0 on the same edge.
REQ-028 LOSS_COUNT SHALL saturate at 255 and never wrap.
REQ-029 If CLR_LOSS and a loss occur on the same cycle, LOSS_COUNT SHALL become 1.
REQ-030 A lock_s glitch shorter than STABLE_CYCLES during STABILIZE SHALL restart qualification from WAIT_LOCK.

Reset
REQ-031 M2F_RESET_N=0 sampled on an FAB_CLK edge SHALL set: state WAIT_LOCK, cnt=0, divider=0, synchronizer flops=0, all RST_N_STAGEx=0, LOCK_OK=0, TICK=0, LOSS_COUNT=0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence without incrementing LOSS_COUNT.
REQ-033 After reset release, the block SHALL re-qualify lock from WAIT_LOCK even if FAB_LOCK is steadily high.

Verification
REQ-034 Bench parameters SHALL be STABLE_CYCLES=8, STAGE_GAP=4, TICK_DIV=5 for all scenarios below.
REQ-035 Power-up: reset 3 cycles then release, FAB_LOCK high from edge 0 -> STAGE0 rises after edge 10, STAGE1 after edge 14, STAGE2/LOCK_OK after edge 18, first TICK after edge 23, then every 5 cycles.
REQ-036 Glitch: FAB_LOCK low for 2 cycles during STABILIZE -> all stages stay 0, LOSS_COUNT=1, release re-timed from the new lock rise.
REQ-037 Lock loss in RUN: lock_s falls -> STAGE0/1/2, LOCK_OK and TICK all 0 on the same edge, LOSS_COUNT increments by 1.
REQ-038 Saturation: 260 loss events -> LOSS_COUNT=255; then CLR_LOSS together with a loss -> LOSS_COUNT=1.
REQ-039 Reset in REL1: M2F_RESET_N=0 -> all outputs 0, LOSS_COUNT=0; after release, the full 8+4+4 sequence repeats.
